// File: rtl/regbank_arb_pkg.sv
// Shared helpers for the register-bank write arbiter: index-width derivation
// and the address-to-select decode with the out-of-range rule.
package regbank_arb_pkg;

  // clog2 that never yields a zero-width field (depth/num of 1 still needs a bit)
  function automatic int calc_addr_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // One bit of the one-hot select: entry idx is selected by addr only when
  // addr names a real entry; addresses at or beyond depth select nothing.
  function automatic logic decode_sel_bit(input logic [31:0] addr,
                                          input int unsigned idx,
                                          input int unsigned depth);
    return (addr < 32'(depth)) && (addr == 32'(idx));
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo num_req. Returns one-hot grant and its binary index.
module rr_priority_pick
  import regbank_arb_pkg::*;
#(
  parameter int num_req = 2,
  parameter int idx_w   = 1
) (
  input  logic [num_req-1:0] req_i,
  input  logic [idx_w-1:0]   ptr_i,
  output logic [num_req-1:0] grant_o,
  output logic [idx_w-1:0]   grant_idx_o
);

  always_comb begin
    logic found;
    int   idx;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < num_req; k++) begin
      idx = (int'(ptr_i) + k) % num_req;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx_w'(idx);
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin write-port arbiter for the one-hot register bank; registers one
// bank write per cycle. Optional macro REGBANK_ZERO_PROTECT_EN makes entry 0 read-only.
module regbank_write_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int mem_width = 16,
  parameter int mem_depth = 16,
  parameter int num_req   = 2,
  localparam int addr_w   = calc_addr_w(mem_depth)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [num_req-1:0]            req_valid,
  input  logic [num_req*addr_w-1:0]     req_addr,
  input  logic [num_req*mem_width-1:0]  req_data,
  output logic [num_req-1:0]            req_ready,
  input  logic                          hold,
  output logic                          we,
  output logic [mem_depth-1:0]          S,
  output logic [mem_width-1:0]          Rin,
  output logic [num_req-1:0]            last_grant
);

  localparam int idx_w = calc_addr_w(num_req);

  logic [idx_w-1:0]     ptr_q, ptr_d;
  logic                 we_q, we_d;
  logic [mem_depth-1:0] s_q, s_d;
  logic [mem_width-1:0] rin_q, rin_d;
  logic [num_req-1:0]   lg_q, lg_d;

  logic [num_req-1:0]   pick_grant;
  logic [idx_w-1:0]     pick_idx;
  logic                 accept;
  logic [addr_w-1:0]    gnt_addr;
  logic [mem_width-1:0] gnt_data;
  logic [mem_depth-1:0] sel;
  logic                 wr_ok;

  rr_priority_pick #(
    .num_req(num_req),
    .idx_w  (idx_w)
  ) u_pick (
    .req_i      (req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (pick_grant),
    .grant_idx_o(pick_idx)
  );

  // Ready never looks at data, only valid/hold/ptr (and reset)
  assign req_ready = (reset || hold) ? '0 : pick_grant;
  assign accept    = |req_ready;
  assign gnt_addr  = req_addr[int'(pick_idx)*addr_w +: addr_w];
  assign gnt_data  = req_data[int'(pick_idx)*mem_width +: mem_width];

  always_comb begin
    sel = '0;
    for (int j = 0; j < mem_depth; j++) begin
      sel[j] = decode_sel_bit(32'(gnt_addr), unsigned'(j), unsigned'(mem_depth));
    end
  end

`ifdef REGBANK_ZERO_PROTECT_EN
  assign wr_ok = (gnt_addr != '0);
`else
  assign wr_ok = 1'b1;
`endif

  always_comb begin
    ptr_d = ptr_q;
    we_d  = 1'b0;
    s_d   = '0;
    rin_d = rin_q;
    lg_d  = lg_q;
    if (accept) begin
      ptr_d = (int'(pick_idx) == num_req - 1) ? '0 : idx_w'(int'(pick_idx) + 1);
      // out-of-range addresses decode to an empty select, which also drops we
      we_d  = wr_ok && (|sel);
      s_d   = wr_ok ? sel : '0;
      rin_d = gnt_data;
      lg_d  = req_ready;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      we_q  <= 1'b0;
      s_q   <= '0;
      rin_q <= '0;
      lg_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q  <= we_d;
      s_q   <= s_d;
      rin_q <= rin_d;
      lg_q  <= lg_d;
    end
  end

  assign we         = we_q;
  assign S          = s_q;
  assign Rin        = rin_q;
  assign last_grant = lg_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench for regbank_write_arbiter: stimulus pushes expected writes,
// a monitor pops and compares whenever the DUT accepts a request.
module tb_regbank_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_ready;
  logic        hold;
  logic        we;
  logic [15:0] S;
  logic [15:0] Rin;
  logic [1:0]  last_grant;

  logic        v12;
  logic [3:0]  a12;
  logic [15:0] d12;
  logic        rdy12;
  logic        we12;
  logic [11:0] s12;
  logic [15:0] rin12;
  logic        lg12;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  g;
    logic        we;
    logic [15:0] s;
    logic [15:0] rin;
    logic [1:0]  lg;
  } exp_t;

  exp_t exp_q[$];

  regbank_write_arbiter #(.mem_width(16), .mem_depth(16), .num_req(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold), .we(we),
    .S(S), .Rin(Rin), .last_grant(last_grant)
  );

  regbank_write_arbiter #(.mem_width(16), .mem_depth(12), .num_req(1)) dut12 (
    .clk(clk), .reset(reset), .req_valid(v12), .req_addr(a12),
    .req_data(d12), .req_ready(rdy12), .hold(1'b0), .we(we12),
    .S(s12), .Rin(rin12), .last_grant(lg12)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic w, input logic [15:0] s,
                      input logic [15:0] rin, input logic [1:0] lg);
    exp_t e;
    e.g = g; e.we = w; e.s = s; e.rin = rin; e.lg = lg;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [1:0] v, input logic [3:0] a0, input logic [15:0] d0,
                     input logic [3:0] a1, input logic [15:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    @(posedge clk);
    #1;
  endtask

  // Monitor: an accepted grant seen before an edge is checked after that edge
  initial begin
    logic [1:0] g;
    exp_t e;
    forever begin
      @(negedge clk);
      g = req_ready;
      if (g != 2'b00) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: got %0b expected none", g);
          @(posedge clk);
          #1;
        end else begin
          e = exp_q.pop_front();
          chk("grant", 64'(g), 64'(e.g));
          @(posedge clk);
          #1;
          chk("we", 64'(we), 64'(e.we));
          chk("S", 64'(S), 64'(e.s));
          chk("Rin", 64'(Rin), 64'(e.rin));
          chk("last_grant", 64'(last_grant), 64'(e.lg));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = 2'b11;
    req_addr  = 8'h21;
    req_data  = 32'h1234_5678;
    v12 = 1'b0; a12 = 4'd0; d12 = 16'h0;
    #2;
    chk("rst_ready", 64'(req_ready), 64'(2'b00));
    chk("rst_we", 64'(we), 64'(1'b0));
    chk("rst_S", 64'(S), 64'(16'h0));
    chk("rst_Rin", 64'(Rin), 64'(16'h0));
    chk("rst_lg", 64'(last_grant), 64'(2'b00));
    @(posedge clk);
    #1;
    chk("rst_hold_we", 64'(we), 64'(1'b0));
    req_valid = 2'b00;
    reset     = 1'b0;

    // single write: req0 addr 5 data A5A5
    push(2'b01, 1'b1, 16'h0020, 16'hA5A5, 2'b01);
    cyc(2'b01, 4'd5, 16'hA5A5, 4'd0, 16'h0);
    cyc(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);

    // reset pulse to put ptr back to 0
    reset = 1'b1;
    cyc(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
    reset = 1'b0;

    // contention: alternate 0,1,0,1,0,1
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push(2'b01, 1'b1, 16'h0004, 16'h1111, 2'b01);
      else            push(2'b10, 1'b1, 16'h0200, 16'h2222, 2'b10);
      cyc(2'b11, 4'd2, 16'h1111, 4'd9, 16'h2222);
    end
    // one more grant to req0 so req1 is next in line
    push(2'b01, 1'b1, 16'h0004, 16'h1111, 2'b01);
    cyc(2'b01, 4'd2, 16'h1111, 4'd9, 16'h2222);

    // hold with both valid: no grants, bubbles, Rin holds
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b11;
      @(negedge clk);
      chk("hold_ready", 64'(req_ready), 64'(2'b00));
      @(posedge clk);
      #1;
      chk("hold_we", 64'(we), 64'(1'b0));
      chk("hold_S", 64'(S), 64'(16'h0));
      chk("hold_Rin", 64'(Rin), 64'(16'h1111));
    end
    hold = 1'b0;
    push(2'b10, 1'b1, 16'h0200, 16'h2222, 2'b10);
    cyc(2'b11, 4'd2, 16'h1111, 4'd9, 16'h2222);
    // back-to-back grants to a lone requester
    push(2'b10, 1'b1, 16'h0200, 16'h2222, 2'b10);
    cyc(2'b10, 4'd2, 16'h1111, 4'd9, 16'h2222);
    push(2'b10, 1'b1, 16'h0400, 16'h2B2B, 2'b10);
    cyc(2'b10, 4'd2, 16'h1111, 4'd10, 16'h2B2B);
    cyc(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);

    // mid-operation reset clears the registered write immediately
    push(2'b01, 1'b1, 16'h0008, 16'h3333, 2'b01);
    cyc(2'b01, 4'd3, 16'h3333, 4'd9, 16'h2222);
    req_valid = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_we", 64'(we), 64'(1'b0));
    chk("midrst_S", 64'(S), 64'(16'h0));
    chk("midrst_Rin", 64'(Rin), 64'(16'h0));
    chk("midrst_lg", 64'(last_grant), 64'(2'b00));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_we", 64'(we), 64'(1'b0));

    // write to address 0 from req1
`ifdef REGBANK_ZERO_PROTECT_EN
    push(2'b10, 1'b0, 16'h0000, 16'hFFFF, 2'b10);
`else
    push(2'b10, 1'b1, 16'h0001, 16'hFFFF, 2'b10);
`endif
    cyc(2'b10, 4'd0, 16'h0, 4'd0, 16'hFFFF);
    cyc(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);

    // 12-entry, single-requester instance: in-range then out-of-range
    v12 = 1'b1; a12 = 4'd11; d12 = 16'hBEEF;
    @(negedge clk);
    chk("d12_ready_in", 64'(rdy12), 64'(1'b1));
    @(posedge clk);
    #1;
    chk("d12_we_in", 64'(we12), 64'(1'b1));
    chk("d12_S_in", 64'(s12), 64'(12'h800));
    chk("d12_Rin_in", 64'(rin12), 64'(16'hBEEF));
    a12 = 4'd13; d12 = 16'hCAFE;
    @(negedge clk);
    chk("d12_ready_oor", 64'(rdy12), 64'(1'b1));
    @(posedge clk);
    #1;
    chk("d12_we_oor", 64'(we12), 64'(1'b0));
    chk("d12_S_oor", 64'(s12), 64'(12'h000));
    chk("d12_Rin_oor", 64'(rin12), 64'(16'hCAFE));
    chk("d12_lg_oor", 64'(lg12), 64'(1'b1));
    v12 = 1'b0;
    @(posedge clk);
    #1;
    chk("d12_idle_we", 64'(we12), 64'(1'b0));
    chk("d12_idle_Rin", 64'(rin12), 64'(16'hCAFE));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Write-port arbiter and sequencer for the one-hot-selected DFF register bank. Shares the bank's single write port (`Rin`, `we`, one-hot `S`) among `num_req` writeback requesters using a valid/ready handshake and round-robin priority. It decodes the granted binary address to the one-hot select and registers the write, so exactly one bank write issues per cycle. It sits between the execute/load writeback paths and the register bank.

## Interface
Parameters:
- `mem_width`, default 16: data width of one bank entry.
- `mem_depth`, default 16: number of bank entries; also the width of `S`.
- `num_req`, default 2: number of writeback requesters, minimum 1.
- `addr_w`: localparam, equal to `$clog2(mem_depth)`, with a minimum of 1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  num_req  requester i holds a pending write.
- `req_addr`  in  num_req*addr_w  packed binary addresses; requester i occupies bits `[(i+1)*addr_w-1 : i*addr_w]`.
- `req_data`  in  num_req*mem_width  packed write data, packed the same way.
- `req_ready`  out  num_req  one-hot or zero; marks the requester whose write is accepted this cycle.
- `hold`  in  1  freezes arbitration; no grants while high.
- `we`  out  1  bank write enable.
- `S`  out  mem_depth  one-hot bank select.
- `Rin`  out  mem_width  bank write data.
- `last_grant`  out  num_req  one-hot, registered copy of the most recent accepted grant.

## Operation
- A request is accepted in a cycle when both `req_valid[i]` and `req_ready[i]` are high. At most one request is accepted per cycle.
- `req_ready` is combinational: it depends on `req_valid`, `hold` and the priority pointer `ptr`. It must not depend on `req_data`.
- Round-robin rule:
  - Search starts at `ptr` and proceeds in increasing index order, wrapping modulo `num_req`.
  - The first valid requester found is granted.
  - After a grant to requester i, `ptr` becomes `(i+1) mod num_req`.
  - With no grant, `ptr` is unchanged.
- When `hold` is high:
  - `req_ready` is all zero.
  - `ptr` is frozen.
  - The output register loads a bubble: `we`=0, `S`=0. `Rin` holds its last value.
- On acceptance, the output register loads:
  - `we`=1
  - `S`=one-hot decode of the granted address
  - `Rin`=the granted data
  - `last_grant`=the grant vector
- With no acceptance, `we` and `S` are loaded with 0, while `Rin` and `last_grant` hold their values.
- An address ≥ `mem_depth` (possible when `mem_depth` is not a power of two) is still accepted, but produces `we`=0 and `S`=0. The write is dropped silently.
- Requesters must hold `req_addr`/`req_data` stable while `req_valid` is high and not yet accepted. Deasserting `req_valid` before acceptance is permitted.

## Timing
- Accept in cycle t → `we`/`S`/`Rin` valid throughout cycle t+1 → bank captures at the rising edge ending t+1 → new value visible at the bank's `Rout` in cycle t+2.
- Throughput is one write per cycle. Back-to-back grants are allowed, including to the same requester when it is the only one valid.
- With all `num_req` requesters continuously valid, each requester is granted exactly once in every `num_req` consecutive cycles.
- Reset values: `ptr`=0, `we`=0, `S`=0, `Rin`=0, `last_grant`=0. `req_ready` is 0 while `reset` is high.
- Reset asserted mid-operation clears the registered write asynchronously. A write accepted in the cycle `reset` rises is discarded and never reaches the bank.
- `hold` rising in a cycle t: any grant from cycle t-1 still issues its write in cycle t. Hold therefore blocks new acceptances only.

## Configuration
- `REGBANK_ZERO_PROTECT_EN` defined:
  - Entry 0 is hardwired, as for RISC-V x0.
  - A request addressed to 0 is still granted (handshake completes, `ptr` advances, `last_grant` updates).
  - The registered write has `we`=0 and `S`=0.
- `REGBANK_ZERO_PROTECT_EN` not defined: address 0 is written like any other entry.

## Structure
- Shared package `regbank_arb_pkg` holds:
  - the `addr_w` derivation helper (clog2 with a minimum of 1);
  - the one-hot decode function for address → `S`, including the out-of-range → 0 rule.
- One sub-module, `rr_priority_pick`:
  - inputs: `num_req`-wide request vector and pointer;
  - outputs: one-hot grant and the granted index;
  - purely combinational.
- The top level holds `ptr`, the output register, and the data/address muxes.

## Test plan
- Reset then a single write: requester 0 writes addr 5, data 16'hA5A5 at cycle t → in cycle t+1, `we`=1, `S`=16'h0020, `Rin`=16'hA5A5; `last_grant`=2'b01.
- Contention: both requesters continuously valid for 6 cycles after reset → grants alternate 0,1,0,1,0,1; `S` follows each requester's address one cycle later.
- Hold: `hold`=1 for 3 cycles with both requesters valid → `req_ready`=0 and `we`=0 for those cycles; `ptr` is unchanged, so the first grant after release goes to the same requester that would have been next.
- Mid-operation reset: accept a write to addr 3, assert `reset` in the next cycle before the clock edge → `we`=0 and `S`=0 immediately; the bank is not written.
- Zero protect: with the macro defined, requester 1 writes addr 0, data 16'hFFFF → `req_ready[1]`=1, `last_grant`=2'b10, `we`=0, `S`=0. Without the macro → `we`=1, `S`=16'h0001.
- Out-of-range address: `mem_depth`=12, requester 0 writes addr 13 → accepted, `we`=0, `S`=0.
